timer_sched: RTL and testbench
==============================

# timer_sched

Two-requester timer scheduler built around the team's free-running 8-bit counter datapath. It arbitrates round-robin between two requesters for a single shared 8-bit timer. It loads the winner's timeout, runs the count, and returns a one-cycle completion pulse to the owner. It sits between the control logic that needs delays and the counter, which it owns, clears and steps.

## Interface
Parameters:
- WIDTH, 8, width of the timeout and count.

Ports:
- newclk_k  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req  in  2  request per requester; must be held high until its `done` bit is seen.
- tmo0  in  WIDTH  timeout for requester 0; sampled only at grant.
- tmo1  in  WIDTH  timeout for requester 1; sampled only at grant.
- gnt  out  2  one-hot owner of the timer; 00 when free.
- done  out  2  one-cycle completion pulse to the owner.
- busy  out  1  high whenever the state is not IDLE.
- cnt  out  WIDTH  current count, for observation.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Registers:
  - `cmp_r`: latched timeout.
  - `last_r`: index of the last requester served.
- Reset (`rst`=1 at an edge) sets: gnt=00, done=00, busy=0, cnt=0, cmp_r=0, last_r=1. With last_r=1, requester 0 wins the first tie.
- IDLE:
  - If req=00, nothing changes.
  - Otherwise pick a winner. A single requester wins outright. If both request, the winner is the index ≠ last_r.
  - At the edge: gnt=onehot(winner), cmp_r=tmo(winner), cnt=0, last_r=winner, state→RUN.
- RUN, checks in priority order at each edge:
  - Owner's req=0 (abort): gnt=00, cnt held, no done, state→IDLE.
  - cnt==cmp_r: done=onehot(owner), gnt=00, state→DONE.
  - Otherwise: cnt=cnt+1.
- DONE: done returns to 00 at the next edge and state→IDLE. req is ignored while in DONE.
- Arithmetic:
  - cnt never exceeds cmp_r, so there is no wrap-around.
  - cmp_r=255 is legal and counts up to 255.
  - cnt stays at its final value after done or abort until the next grant clears it.
- tmo0/tmo1 changing during RUN has no effect.
- If a requester keeps req high after done, it is re-arbitrated in IDLE. It is re-granted only if the other requester is idle.
- gnt and done are never both nonzero for different requesters. done is only ever asserted for the bit that was granted.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- Let req be sampled high in IDLE at edge k, with timeout N:
  - After edge k: gnt set, busy=1, cnt=0.
  - After edge k+j (j≤N): cnt=j.
  - After edge k+N+1: done pulse, gnt=00.
  - After edge k+N+2: done=00, state IDLE, busy=0.
  - Earliest next grant is after edge k+N+3.
- Grant-to-done latency is N+1 cycles.
- For N=0, done follows one cycle after the grant.
- Abort: req low at edge m during RUN gives gnt=00 and busy=0 after edge m.
- Reset mid-operation: everything returns to reset values at that edge. No done pulse is generated for the interrupted request.
- Reset has priority over every other event at the same edge.

## Test plan
- Reset: hold rst=1 for 2 cycles with req=11 → gnt=00, done=00, busy=0, cnt=0 throughout. First grant after release goes to requester 0.
- Single request: req=01, tmo0=5 → gnt=01 one cycle later; cnt steps 0..5; done=01 for exactly one cycle, 6 cycles after grant, with gnt=00 in the same cycle; busy drops the following cycle.
- Tie and rotation: req=11, tmo0=3, tmo1=2, each req dropped after its done → gnt=01 and done=01 first, then gnt=10 and done=10. Repeating with req=11 again grants 01 first (last_r=1).
- Zero timeout: req=10, tmo1=0 → gnt=10, then done=10 on the very next cycle.
- Abort with pending request: req=11, tmo0=10; drop req[0] when cnt=2 → gnt=00 next cycle with no done; requester 1 granted one cycle later.
- Reset mid-RUN: tmo0=8, assert rst at cnt=4 → gnt=00, cnt=0, busy=0 after that edge; done stays 00.

Source files
------------

// File: rtl/timer_sched.sv
// Two-requester round-robin scheduler that owns one shared up-counting timer.
// A winner's timeout is latched at grant; the owner gets a one-cycle done pulse when the count reaches it.
module timer_sched #(
  parameter int WIDTH = 8
) (
  input  logic             newclk_k,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] tmo0,
  input  logic [WIDTH-1:0] tmo1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic [WIDTH-1:0] cnt,
  output logic [1:0]       state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Handshake: a requester raises req[i] and holds it until done[i] is seen;
  // dropping it while granted aborts the run without a done pulse.

  logic [1:0]       state_r;
  logic [WIDTH-1:0] cmp_r;
  logic             last_r;
  logic             winner;
  logic             owner;

  assign state = state_r;
  assign busy  = (state_r != IDLE);
  assign owner = gnt[1];

  // On a tie the requester that was not served last wins.
  always_comb begin
    winner = 1'b0;
    if (req == 2'b11) winner = ~last_r;
    else              winner = req[1];
  end

  always_ff @(posedge newclk_k) begin
    if (rst) begin
      state_r <= IDLE;
      gnt     <= 2'b00;
      done    <= 2'b00;
      cnt     <= '0;
      cmp_r   <= '0;
      last_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (req != 2'b00) begin
            gnt     <= winner ? 2'b10 : 2'b01;
            cmp_r   <= winner ? tmo1 : tmo0;
            cnt     <= '0;
            last_r  <= winner;
            state_r <= RUN;
          end
        end
        RUN: begin
          if (!req[owner]) begin
            gnt     <= 2'b00;
            state_r <= IDLE;
          end else if (cnt == cmp_r) begin
            done    <= gnt;
            gnt     <= 2'b00;
            state_r <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done    <= 2'b00;
          state_r <= IDLE;
        end
        default: begin
          gnt     <= 2'b00;
          done    <= 2'b00;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched: reset, zero timeout, tie rotation, abort, single request, reset mid-run.
module tb_timer_sched;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [7:0] tmo0;
  logic [7:0] tmo1;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       busy;
  logic [7:0] cnt;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  logic [12:0] exp_v;
  logic [12:0] obs;

  assign obs = {gnt, done, busy, cnt};

  timer_sched #(.WIDTH(8)) dut (
    .newclk_k (clk),
    .rst      (rst),
    .req      (req),
    .tmo0     (tmo0),
    .tmo1     (tmo1),
    .gnt      (gnt),
    .done     (done),
    .busy     (busy),
    .cnt      (cnt),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b11; tmo0 = 8'd7; tmo1 = 8'd7;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_v = {2'b00, 2'b00, 1'b0, 8'd0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_hold[%0d] gnt/done/busy/cnt got=%h want=%h", i, obs, exp_v);
      end
    end
    rst = 1'b0;
    tick();
    exp_v = {2'b01, 2'b00, 1'b1, 8'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_first_grant got=%h want=%h", obs, exp_v);
    end
    req = 2'b00;
    tick();
    exp_v = {2'b00, 2'b00, 1'b0, 8'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_release_abort got=%h want=%h", obs, exp_v);
    end
    tick();
  endtask

  task automatic test_zero_timeout();
    req = 2'b10; tmo1 = 8'd0;
    tick();
    exp_v = {2'b10, 2'b00, 1'b1, 8'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL zero_grant got=%h want=%h", obs, exp_v);
    end
    tick();
    exp_v = {2'b00, 2'b10, 1'b1, 8'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL zero_done got=%h want=%h", obs, exp_v);
    end
    req = 2'b00;
    tick();
    exp_v = {2'b00, 2'b00, 1'b0, 8'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL zero_idle got=%h want=%h", obs, exp_v);
    end
  endtask

  task automatic test_tie_rotation();
    for (int r = 0; r < 2; r++) begin
      req = 2'b11; tmo0 = 8'd3; tmo1 = 8'd2;
      tick();
      exp_v = {2'b01, 2'b00, 1'b1, 8'd0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL tie_first_grant[%0d] got=%h want=%h", r, obs, exp_v);
      end
      for (int j = 1; j <= 3; j++) tick();
      exp_v = {2'b01, 2'b00, 1'b1, 8'd3};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL tie_cnt0[%0d] got=%h want=%h", r, obs, exp_v);
      end
      tick();
      exp_v = {2'b00, 2'b01, 1'b1, 8'd3};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL tie_done0[%0d] got=%h want=%h", r, obs, exp_v);
      end
      req = 2'b10;
      tick();
      exp_v = {2'b00, 2'b00, 1'b0, 8'd3};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL tie_gap[%0d] got=%h want=%h", r, obs, exp_v);
      end
      tick();
      exp_v = {2'b10, 2'b00, 1'b1, 8'd0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL tie_second_grant[%0d] got=%h want=%h", r, obs, exp_v);
      end
      tick();
      tick();
      tick();
      exp_v = {2'b00, 2'b10, 1'b1, 8'd2};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL tie_done1[%0d] got=%h want=%h", r, obs, exp_v);
      end
      req = 2'b00;
      tick();
    end
  endtask

  task automatic test_abort();
    req = 2'b11; tmo0 = 8'd10; tmo1 = 8'd1;
    tick();
    exp_v = {2'b01, 2'b00, 1'b1, 8'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL abort_grant got=%h want=%h", obs, exp_v);
    end
    tick();
    tick();
    req = 2'b10;
    tick();
    exp_v = {2'b00, 2'b00, 1'b0, 8'd2};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL abort_drop got=%h want=%h", obs, exp_v);
    end
    tick();
    exp_v = {2'b10, 2'b00, 1'b1, 8'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL abort_pending_grant got=%h want=%h", obs, exp_v);
    end
    tick();
    tick();
    exp_v = {2'b00, 2'b10, 1'b1, 8'd1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL abort_pending_done got=%h want=%h", obs, exp_v);
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_single();
    req = 2'b01; tmo0 = 8'd5;
    tick();
    exp_v = {2'b01, 2'b00, 1'b1, 8'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL single_grant got=%h want=%h", obs, exp_v);
    end
    tmo0 = 8'd200;
    for (int j = 1; j <= 5; j++) begin
      tick();
      exp_v = {2'b01, 2'b00, 1'b1, 8'(j)};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL single_cnt[%0d] got=%h want=%h", j, obs, exp_v);
      end
    end
    tick();
    exp_v = {2'b00, 2'b01, 1'b1, 8'd5};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL single_done got=%h want=%h", obs, exp_v);
    end
    req = 2'b00;
    tick();
    exp_v = {2'b00, 2'b00, 1'b0, 8'd5};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL single_idle got=%h want=%h", obs, exp_v);
    end
  endtask

  task automatic test_reset_mid_run();
    req = 2'b01; tmo0 = 8'd8;
    tick();
    for (int j = 1; j <= 4; j++) tick();
    exp_v = {2'b01, 2'b00, 1'b1, 8'd4};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL midrst_before got=%h want=%h", obs, exp_v);
    end
    rst = 1'b1;
    tick();
    exp_v = {2'b00, 2'b00, 1'b0, 8'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL midrst_after got=%h want=%h", obs, exp_v);
    end
    rst = 1'b0; req = 2'b00;
    tick();
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL midrst_no_done got=%h want=%h", obs, exp_v);
    end
  endtask

  initial begin
    rst = 1'b1; req = 2'b00; tmo0 = 8'd0; tmo1 = 8'd0;
    test_reset();
    test_zero_timeout();
    test_tie_rotation();
    test_abort();
    test_single();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
